// File: rtl/axi_ram_bist.sv
// Purpose : AXI4 write-then-read RAM self test. Fills a region with an address-derived pattern, then reads it back and checks every beat.
// Latency : one AXI transaction in flight at a time. o_done rises the cycle after the final read beat handshake.
// Backpr. : each valid is held with a stable payload until its ready. o_bready/o_rready are asserted for the whole response phase.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start                    start pulse, accepted only when idle or done
//   o_busy, o_done, o_error    status; o_done holds until the next accepted start
//   o_err_count, o_err_addr    saturating error count, byte address of the first failing beat
//   o_aw*/o_w*/i_b*/o_ar*/i_r* AXI4 initiator channels (64-bit data, INCR bursts)
module axi_ram_bist #(
  parameter int unsigned ID_WIDTH  = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_BEATS = 64,
  parameter int unsigned BURST_LEN = 8,
  parameter logic [31:0] SEED      = 32'h5A5A_0F0F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [15:0]         o_err_count,
  output logic [31:0]         o_err_addr,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0] LAST_BURST  = 32'(NUM_BEATS / BURST_LEN - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;       // start address of the current burst
  logic [31:0] r_burst;      // burst index within the current phase
  logic [7:0]  r_beat;       // beat index within the current burst
  logic [15:0] r_err_count;
  logic [31:0] r_err_addr;

  logic [31:0] w_beat_addr;
  logic [63:0] w_pattern;
  logic        w_last_beat;
  logic        w_last_burst;
  logic        w_start;
  logic        w_err_evt;
  logic [31:0] w_err_at;
  logic        w_unused;

  // Response IDs are not checked: only one transaction is ever outstanding.
  assign w_unused = ^{i_bid, i_rid};

  assign w_beat_addr  = r_addr + {21'd0, r_beat, 3'd0};
  assign w_pattern    = {w_beat_addr ^ SEED, ~w_beat_addr};
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_last_burst = (r_burst == LAST_BURST);
  assign w_start      = i_start && (r_state == S_IDLE || r_state == S_DONE);

  // A write burst fails on a non-OKAY bresp; a read beat fails on data, rresp,
  // or rlast disagreeing with the internal beat count (one error per beat).
  always_comb begin
    w_err_evt = 1'b0;
    w_err_at  = r_addr;
    if (r_state == S_WRESP && i_bvalid) begin
      w_err_evt = (i_bresp != 2'b00);
      w_err_at  = r_addr;
    end else if (r_state == S_RDATA && i_rvalid) begin
      w_err_evt = (i_rdata != w_pattern) || (i_rresp != 2'b00) || (i_rlast != w_last_beat);
      w_err_at  = w_beat_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_next = S_WADDR;
      end
      S_WADDR: begin
        o_awvalid = 1'b1;
        if (i_awready) w_next = S_WDATA;
      end
      S_WDATA: begin
        o_wvalid = 1'b1;
        if (i_wready && w_last_beat) w_next = S_WRESP;
      end
      S_WRESP: begin
        o_bready = 1'b1;
        if (i_bvalid) w_next = w_last_burst ? S_RADDR : S_WADDR;
      end
      S_RADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_RDATA;
      end
      S_RDATA: begin
        o_rready = 1'b1;
        // The internal beat count ends the burst, not i_rlast.
        if (i_rvalid && w_last_beat) w_next = w_last_burst ? S_DONE : S_RADDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_burst     <= '0;
      r_beat      <= '0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      if (w_start) begin
        r_addr      <= BASE_ADDR;
        r_burst     <= '0;
        r_beat      <= '0;
        r_err_count <= '0;
        r_err_addr  <= '0;
      end

      if ((r_state == S_WDATA && i_wready) || (r_state == S_RDATA && i_rvalid)) begin
        r_beat <= w_last_beat ? 8'd0 : r_beat + 8'd1;
      end

      // Advance to the next burst after a write response or the last read beat;
      // the write phase rewinds to BASE_ADDR for the read phase.
      if ((r_state == S_WRESP && i_bvalid) || (r_state == S_RDATA && i_rvalid && w_last_beat)) begin
        if (w_last_burst) begin
          r_addr  <= BASE_ADDR;
          r_burst <= '0;
        end else begin
          r_addr  <= r_addr + BURST_BYTES;
          r_burst <= r_burst + 32'd1;
        end
      end

      if (w_err_evt) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        if (r_err_count == 16'd0) r_err_addr <= w_err_at;
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_error     = (r_err_count != 16'd0);
  assign o_err_count = r_err_count;
  assign o_err_addr  = r_err_addr;

  assign o_awid    = '0;
  assign o_awaddr  = r_addr;
  assign o_awlen   = LAST_BEAT;
  assign o_awsize  = 3'b011;
  assign o_awburst = 2'b01;
  assign o_wdata   = w_pattern;
  assign o_wstrb   = 8'hFF;
  assign o_wlast   = w_last_beat;
  assign o_arid    = '0;
  assign o_araddr  = r_addr;
  assign o_arlen   = LAST_BEAT;
  assign o_arsize  = 3'b011;
  assign o_arburst = 2'b01;

endmodule

// File: tb/tb_axi_ram_bist.sv
// Purpose : self-checking bench for axi_ram_bist with a behavioural AXI RAM responder.
// Latency : responder reacts on the falling edge; stalls are randomized per channel.
// Backpr. : ready/valid stalls of random length; held payloads are checked for stability.
module tb_axi_ram_bist;

  localparam int          IDW   = 6;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          BEATS = 64;
  localparam int          BL    = 8;
  localparam logic [31:0] SEED  = 32'h5A5A_0F0F;
  localparam int          NBUR  = BEATS / BL;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic            o_busy, o_done, o_error;
  logic [15:0]     o_err_count;
  logic [31:0]     o_err_addr;
  logic [IDW-1:0]  o_awid, o_arid, i_bid, i_rid;
  logic [31:0]     o_awaddr, o_araddr;
  logic [7:0]      o_awlen, o_arlen, o_wstrb;
  logic [2:0]      o_awsize, o_arsize;
  logic [1:0]      o_awburst, o_arburst, i_bresp, i_rresp;
  logic            o_awvalid, i_awready, o_wlast, o_wvalid, i_wready;
  logic            i_bvalid, o_bready, o_arvalid, i_arready;
  logic            i_rlast, i_rvalid, o_rready;
  logic [63:0]     o_wdata, i_rdata;

  always #5 clk = ~clk;

  axi_ram_bist #(
    .ID_WIDTH(IDW), .BASE_ADDR(BASE), .NUM_BEATS(BEATS), .BURST_LEN(BL), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_count(o_err_count), .o_err_addr(o_err_addr),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ SEED, ~a};
  endfunction

  function automatic int widx(input logic [31:0] base, input int idx);
    return int'(((base >> 3) + 32'(idx)) & 32'd255);
  endfunction

  // Responder / scoreboard state
  logic [63:0]  mem [256];
  bit           stall_en, corrupt_en;
  int           bad_burst;
  logic [31:0]  aw_q[$], ar_q[$];
  logic [63:0]  w_q[$];
  int           w_beats, r_beats, wburst_num, w_idx, r_idx, b_wait;
  bit           aw_open, b_pending, r_pending, b_hs, r_hs;
  logic [31:0]  w_base, r_base;
  bit           aw_stall, w_stall, ar_stall;
  logic [40:0]  aw_saved, ar_saved;
  logic [65:0]  w_saved;

  task automatic resp_reset();
    i_awready = 0; i_wready = 0; i_arready = 0;
    i_bvalid = 0; i_bresp = 0; i_bid = '0;
    i_rvalid = 0; i_rdata = '0; i_rresp = 0; i_rlast = 0; i_rid = '0;
    aw_q.delete(); ar_q.delete(); w_q.delete();
    w_beats = 0; r_beats = 0; wburst_num = 0; w_idx = 0; r_idx = 0; b_wait = 0;
    aw_open = 0; b_pending = 0; r_pending = 0; b_hs = 0; r_hs = 0;
    aw_stall = 0; w_stall = 0; ar_stall = 0;
  endtask

  // One responder cycle: drive for the coming rising edge, then record the
  // handshakes that edge will complete.
  task automatic resp_cycle();
    if (b_hs) i_bvalid = 1'b0;
    if (r_hs) i_rvalid = 1'b0;
    b_hs = 0; r_hs = 0;
    i_awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
    i_wready  = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
    i_arready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
    if (b_pending && !i_bvalid) begin
      if (b_wait == 0) begin
        i_bvalid = 1'b1;
        i_bresp  = (wburst_num == bad_burst) ? 2'b10 : 2'b00;
      end else b_wait--;
    end
    if (r_pending && !i_rvalid && (!stall_en || $urandom_range(0, 2) == 0)) begin
      i_rvalid = 1'b1;
      i_rdata  = mem[widx(r_base, r_idx)];
      i_rlast  = (r_idx == BL - 1);
      i_rresp  = 2'b00;
    end
    #1;
    if (aw_stall) chk("aw_hold", {o_awvalid, o_awaddr, o_awlen}, aw_saved);
    if (w_stall)  chk("w_hold", {o_wvalid, o_wlast, o_wdata}, w_saved);
    if (ar_stall) chk("ar_hold", {o_arvalid, o_araddr, o_arlen}, ar_saved);
    aw_stall = o_awvalid && !i_awready; aw_saved = {o_awvalid, o_awaddr, o_awlen};
    w_stall  = o_wvalid && !i_wready;   w_saved  = {o_wvalid, o_wlast, o_wdata};
    ar_stall = o_arvalid && !i_arready; ar_saved = {o_arvalid, o_araddr, o_arlen};
    if (o_wvalid) chk("w_after_aw", aw_open, 1'b1);

    if (o_awvalid && i_awready) begin
      chk("aw_one_out", {aw_open, b_pending, r_pending}, 3'b000);
      chk("aw_const", {o_awid, o_awsize, o_awburst, o_awlen}, {6'd0, 3'd3, 2'd1, 8'(BL - 1)});
      aw_q.push_back(o_awaddr);
      aw_open = 1; w_base = o_awaddr; w_idx = 0;
    end
    if (o_wvalid && i_wready) begin
      chk("w_last_strb", {o_wlast, o_wstrb}, {(w_idx == BL - 1), 8'hFF});
      mem[widx(w_base, w_idx)] = o_wdata;
      w_q.push_back(o_wdata);
      w_beats++; w_idx++;
      if (w_idx == BL) begin
        aw_open = 0; b_pending = 1;
        b_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
      end
    end
    if (i_bvalid && o_bready) begin
      b_hs = 1; b_pending = 0; wburst_num++;
      if (corrupt_en && wburst_num == NBUR) mem[5] = mem[5] ^ 64'h1;
    end
    if (o_arvalid && i_arready) begin
      chk("ar_order", {(wburst_num == NBUR), r_pending, aw_open, b_pending}, 4'b1000);
      chk("ar_const", {o_arid, o_arsize, o_arburst, o_arlen}, {6'd0, 3'd3, 2'd1, 8'(BL - 1)});
      ar_q.push_back(o_araddr);
      r_base = o_araddr; r_idx = 0; r_pending = 1;
    end
    if (i_rvalid && o_rready) begin
      r_hs = 1; r_beats++; r_idx++;
      if (r_idx == BL) r_pending = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) resp_cycle();
    end
  end

  task automatic run_test(input string name, input bit corrupt, input int bad,
                          input bit stall, input bit mid_start, input bit rst_mid);
    bit          pulsed;
    logic [15:0] exp_cnt;
    logic [31:0] exp_addr;
    resp_reset();
    corrupt_en = corrupt; bad_burst = bad; stall_en = stall;
    @(negedge clk); #2; i_start = 1'b1;
    @(negedge clk); #2; i_start = 1'b0;
    chk({name, "_start_busy"}, {o_busy, o_done}, 2'b10);
    chk({name, "_start_clr"}, {o_error, o_err_count, o_err_addr}, '0);
    pulsed = 0;
    for (int cyc = 0; cyc < 5000 && !o_done; cyc++) begin
      if (rst_mid && w_beats == 4) begin
        @(negedge clk); #2;
        chk({name, "_wvalid_pre_rst"}, o_wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk({name, "_rst_valids"}, {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, 5'b0);
        chk({name, "_rst_status"}, {o_busy, o_done, o_error, o_err_count}, '0);
        resp_reset();
        repeat (2) @(negedge clk);
        #2; rst_n = 1'b1;
        @(negedge clk); #2;
        chk({name, "_idle_after_rst"}, {o_busy, o_done, o_awvalid}, 3'b000);
        return;
      end
      if (mid_start && !pulsed && r_beats >= 20) begin
        i_start = 1'b1; pulsed = 1;
        @(negedge clk); #2; i_start = 1'b0;
        chk({name, "_ignored_start"}, {o_busy, o_done}, 2'b10);
      end
      @(negedge clk); #2;
    end
    chk({name, "_done"}, {o_done, o_busy}, 2'b10);

    exp_cnt  = 16'(int'(bad >= 0) + int'(corrupt));
    exp_addr = (bad >= 0) ? BASE + 32'(bad * BL * 8) : (corrupt ? 32'h28 : 32'h0);
    chk({name, "_err_count"}, o_err_count, exp_cnt);
    chk({name, "_err_addr"}, o_err_addr, exp_addr);
    chk({name, "_error"}, o_error, (exp_cnt != 0));

    chk({name, "_aw_count"}, aw_q.size(), NBUR);
    for (int i = 0; i < aw_q.size(); i++) chk({name, "_aw_addr"}, aw_q[i], BASE + 32'(i * BL * 8));
    chk({name, "_w_count"}, w_q.size(), BEATS);
    for (int i = 0; i < w_q.size(); i++) chk({name, "_w_data"}, w_q[i], pat(BASE + 32'(i * 8)));
    chk({name, "_ar_count"}, ar_q.size(), NBUR);
    for (int i = 0; i < ar_q.size(); i++) chk({name, "_ar_addr"}, ar_q[i], BASE + 32'(i * BL * 8));
    chk({name, "_r_beats"}, r_beats, BEATS);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0;
    stall_en = 0; corrupt_en = 0; bad_burst = -1;
    resp_reset();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_ctrl", {o_busy, o_done, o_error, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, 8'h00);
    chk("reset_err", {o_err_count, o_err_addr}, '0);
    rst_n = 1'b1;

    run_test("clean", 0, -1, 0, 0, 0);
    chk("ram_word_0x8", mem[1], 64'h5A5A0F07_FFFFFFF7);
    run_test("corrupt", 1, -1, 0, 0, 0);
    run_test("stall", 0, -1, 1, 0, 0);
    run_test("bresp", 0, 3, 1, 0, 0);
    run_test("midstart", 0, -1, 1, 1, 0);
    run_test("rstmid", 0, -1, 1, 0, 1);
    run_test("after_rst", 0, -1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
